cve2_obi_arbiter: RTL and testbench

- Shares one external OBI-style memory port between the core's instruction-fetch and data (LSU) interfaces, for integrations that expose a single bus master.
- Sits between the core top and the system interconnect.
- Arbitrates requests, holds the selected request stable until it is granted, and tracks outstanding transactions in an in-order ID FIFO.
- Routes each bus response back to the requester that issued it.

---
 rtl/cve2_obi_arbiter.sv | 178 +++++++++++++++++
 tb/tb_cve2_obi_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_obi_arbiter.sv
// Purpose: shares one OBI master port between instruction fetch and LSU, routing responses in order.
// Latency: request, payload and grant are combinational; responses pass straight through in the same cycle.
// Backpressure: holds the selected request until bus_gnt_i; stops requesting while MaxOutstanding are in flight.
module cve2_obi_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RoundRobin     = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic [2:0]  outstanding_o,
  output logic        proto_err_o
);

  localparam int unsigned     PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [2:0]      MaxCnt  = 3'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  // Requester IDs as stored in the FIFO and in owner/last_winner.
  localparam logic OWN_INSTR = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic {IDLE, WAIT_GNT} state_e;

  state_e                    state_q;
  logic                      owner_q;
  logic                      last_q, last_d;
  logic [2:0]                count_q, count_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [MaxOutstanding-1:0] ids_q, ids_d;
  logic                      proto_err_q, proto_err_d;

  logic sel_owner, cur_owner, can_issue, req, grant, pop, head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Arbitration: pick an owner in IDLE, otherwise stay locked to the latched owner.
  always_comb begin
    sel_owner = OWN_INSTR;
    if (data_req_i && !instr_req_i) begin
      sel_owner = OWN_DATA;
    end else if (data_req_i && instr_req_i) begin
      sel_owner = RoundRobin ? ~last_q : OWN_DATA;
    end
    can_issue = (state_q == IDLE) && (count_q < MaxCnt) && (instr_req_i || data_req_i);
    req       = !rst_i && ((state_q == WAIT_GNT) || can_issue);
    cur_owner = (state_q == WAIT_GNT) ? owner_q : sel_owner;
    grant     = req && bus_gnt_i;
    pop       = bus_rvalid_i && (count_q != 3'd0);
    head      = ids_q[rd_ptr_q];
  end

  // Payload mux: instr fetches are always full-word reads; idle bus drives zeros.
  always_comb begin
    bus_req_o   = req;
    bus_we_o    = 1'b0;
    bus_be_o    = 4'h0;
    bus_addr_o  = 32'h0;
    bus_wdata_o = 32'h0;
    if (req) begin
      if (cur_owner == OWN_DATA) begin
        bus_we_o    = data_we_i;
        bus_be_o    = data_be_i;
        bus_addr_o  = data_addr_i;
        bus_wdata_o = data_wdata_i;
      end else begin
        bus_be_o    = 4'hF;
        bus_addr_o  = instr_addr_i;
      end
    end
  end

  // Grant and response routing back to the requesters.
  always_comb begin
    instr_gnt_o    = grant && (cur_owner == OWN_INSTR);
    data_gnt_o     = grant && (cur_owner == OWN_DATA);
    instr_rvalid_o = pop && (head == OWN_INSTR);
    data_rvalid_o  = pop && (head == OWN_DATA);
    instr_rdata_o  = instr_rvalid_o ? bus_rdata_i : 32'h0;
    instr_err_o    = instr_rvalid_o && bus_err_i;
    data_rdata_o   = data_rvalid_o ? bus_rdata_i : 32'h0;
    data_err_o     = data_rvalid_o && bus_err_i;
    outstanding_o  = count_q;
    proto_err_o    = proto_err_q;
  end

  // Next-state for the in-order ID FIFO, last winner and protocol error flag.
  always_comb begin
    ids_d       = ids_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    last_d      = last_q;
    count_d     = count_q;
    proto_err_d = proto_err_q || (bus_rvalid_i && (count_q == 3'd0));
    if (grant) begin
      ids_d[wr_ptr_q] = cur_owner;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      last_d          = cur_owner;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({grant, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Request FSM: latch the owner when the first request cycle is not granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OWN_INSTR;
    end else begin
      case (state_q)
        IDLE: begin
          if (can_issue && !bus_gnt_i) begin
            state_q <= WAIT_GNT;
            owner_q <= sel_owner;
          end
        end
        WAIT_GNT: begin
          if (bus_gnt_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outstanding-transaction bookkeeping registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ids_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      last_q      <= OWN_INSTR;
      count_q     <= 3'd0;
      proto_err_q <= 1'b0;
    end else begin
      ids_q       <= ids_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      last_q      <= last_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
// Purpose: directed bench for cve2_obi_arbiter; expected responses queued at grant, checked by a monitor.
// Latency: combinational outputs sampled on the falling edge; inputs driven 1ns after the rising edge.
// Backpressure: bus grant stalls and FIFO-full blocking are driven explicitly by the stimulus.
module tb_cve2_obi_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        instr_req, data_req, data_we;
  logic [31:0] instr_addr, data_addr, data_wdata;
  logic [3:0]  data_be;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  logic        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
  logic [31:0] instr_rdata, data_rdata, bus_addr, bus_wdata;
  logic        bus_req, bus_we, proto_err;
  logic [3:0]  bus_be;
  logic [2:0]  outstanding;

  // Round-robin instance: shares the core-side inputs, has its own bus side.
  logic        bus_gnt_r, bus_rvalid_r;
  logic        instr_gnt_r, instr_rvalid_r, instr_err_r, data_gnt_r, data_rvalid_r, data_err_r;
  logic [31:0] instr_rdata_r, data_rdata_r, bus_addr_r, bus_wdata_r;
  logic        bus_req_r, bus_we_r, proto_err_r;
  logic [3:0]  bus_be_r;
  logic [2:0]  outstanding_r;

  cve2_obi_arbiter #(.MaxOutstanding(2), .RoundRobin(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_err_o(data_err),
    .bus_req_o(bus_req), .bus_gnt_i(bus_gnt), .bus_we_o(bus_we), .bus_be_o(bus_be),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata), .bus_err_i(bus_err),
    .outstanding_o(outstanding), .proto_err_o(proto_err)
  );

  cve2_obi_arbiter #(.MaxOutstanding(2), .RoundRobin(1'b1)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt_r),
    .instr_rvalid_o(instr_rvalid_r), .instr_rdata_o(instr_rdata_r), .instr_err_o(instr_err_r),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt_r), .data_rvalid_o(data_rvalid_r),
    .data_rdata_o(data_rdata_r), .data_err_o(data_err_r),
    .bus_req_o(bus_req_r), .bus_gnt_i(bus_gnt_r), .bus_we_o(bus_we_r), .bus_be_o(bus_be_r),
    .bus_addr_o(bus_addr_r), .bus_wdata_o(bus_wdata_r), .bus_rvalid_i(bus_rvalid_r),
    .bus_rdata_i(bus_rdata), .bus_err_i(bus_err),
    .outstanding_o(outstanding_r), .proto_err_o(proto_err_r)
  );

  typedef struct packed {
    logic        side;   // 1 = data, 0 = instr
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t mon_a;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic side, input logic [31:0] rdata, input logic err);
    sb.push_back('{side: side, err: err, rdata: rdata});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every rvalid on the main instance must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (instr_rvalid || data_rvalid)) begin
      checks++;
      if (instr_rvalid && data_rvalid) begin
        failures++;
        $display("FAIL both_rvalid actual=11 required=one-hot");
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid actual instr=%b data=%b required=none", instr_rvalid, data_rvalid);
      end else begin
        mon_e = sb.pop_front();
        mon_a.side  = data_rvalid;
        mon_a.err   = data_rvalid ? data_err : instr_err;
        mon_a.rdata = data_rvalid ? data_rdata : instr_rdata;
        if (mon_a !== mon_e) begin
          failures++;
          $display("FAIL response actual side=%b err=%b rdata=%h required side=%b err=%b rdata=%h",
                   mon_a.side, mon_a.err, mon_a.rdata, mon_e.side, mon_e.err, mon_e.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    instr_req = 0; data_req = 0; data_we = 0; instr_addr = 0; data_addr = 0; data_wdata = 0;
    data_be = 0; bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = 0;
    bus_gnt_r = 0; bus_rvalid_r = 0;
    #1;
    instr_req = 1; instr_addr = 32'h80; bus_gnt = 1;
    @(negedge clk);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_instr_gnt", {31'd0, instr_gnt}, 32'd0);
    chk("rst_outstanding", {29'd0, outstanding}, 32'd0);
    chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
    chk("rst_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
    tick();
    rst = 0; instr_req = 0; bus_gnt = 0;
    tick();

    // Instr only, granted immediately, response one cycle later.
    instr_req = 1; instr_addr = 32'h80; bus_gnt = 1;
    expect_rsp(1'b0, 32'h0000_0013, 1'b0);
    @(negedge clk);
    chk("t1_instr_gnt", {31'd0, instr_gnt}, 32'd1);
    chk("t1_data_gnt", {31'd0, data_gnt}, 32'd0);
    chk("t1_bus_we", {31'd0, bus_we}, 32'd0);
    chk("t1_bus_be", {28'd0, bus_be}, 32'hF);
    chk("t1_bus_addr", bus_addr, 32'h80);
    chk("t1_bus_wdata", bus_wdata, 32'h0);
    tick();
    instr_req = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("t1_data_rvalid", {31'd0, data_rvalid}, 32'd0);
    chk("t1_instr_rvalid", {31'd0, instr_rvalid}, 32'd1);
    tick();
    bus_rvalid = 0;
    @(negedge clk);
    chk("t1_outstanding", {29'd0, outstanding}, 32'd0);
    tick();

    // Both request, fixed priority: data first, then instr; responses in order.
    data_req = 1; data_we = 1; data_be = 4'h3; data_addr = 32'h1000; data_wdata = 32'hDEADBEEF;
    instr_req = 1; instr_addr = 32'h84; bus_gnt = 1;
    expect_rsp(1'b1, 32'hAAAA_0001, 1'b0);
    @(negedge clk);
    chk("t2_data_gnt", {31'd0, data_gnt}, 32'd1);
    chk("t2_instr_gnt0", {31'd0, instr_gnt}, 32'd0);
    chk("t2_bus_addr", bus_addr, 32'h1000);
    chk("t2_bus_we", {31'd0, bus_we}, 32'd1);
    chk("t2_bus_be", {28'd0, bus_be}, 32'h3);
    chk("t2_bus_wdata", bus_wdata, 32'hDEADBEEF);
    tick();
    data_req = 0;
    expect_rsp(1'b0, 32'h1111_0002, 1'b1);
    @(negedge clk);
    chk("t2_instr_gnt", {31'd0, instr_gnt}, 32'd1);
    chk("t2_bus_addr_i", bus_addr, 32'h84);
    tick();
    instr_req = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'hAAAA_0001; bus_err = 0;
    @(negedge clk);
    chk("t2_outstanding", {29'd0, outstanding}, 32'd2);
    tick();
    bus_rdata = 32'h1111_0002; bus_err = 1;
    tick();
    bus_rvalid = 0; bus_err = 0;
    @(negedge clk);
    chk("t2_outstanding_end", {29'd0, outstanding}, 32'd0);
    tick();

    // Grant stalled 3 cycles on an instr request; data arrives meanwhile and waits.
    instr_req = 1; instr_addr = 32'h200; bus_gnt = 0;
    data_we = 0; data_be = 4'hF; data_addr = 32'h3000; data_wdata = 32'h0;
    @(negedge clk);
    chk("t4_bus_req", {31'd0, bus_req}, 32'd1);
    chk("t4_addr_a", bus_addr, 32'h200);
    tick();
    data_req = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t4_addr_hold", bus_addr, 32'h200);
      chk("t4_no_gnt", {30'd0, instr_gnt, data_gnt}, 32'd0);
      tick();
    end
    bus_gnt = 1;
    expect_rsp(1'b0, 32'h2222_0004, 1'b0);
    @(negedge clk);
    chk("t4_instr_gnt", {30'd0, instr_gnt, data_gnt}, 32'b10);
    chk("t4_addr_gnt", bus_addr, 32'h200);
    tick();
    instr_req = 0;
    expect_rsp(1'b1, 32'h3333_0005, 1'b0);
    @(negedge clk);
    chk("t4_data_gnt", {30'd0, instr_gnt, data_gnt}, 32'b01);
    chk("t4_data_addr", bus_addr, 32'h3000);
    tick();
    data_req = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h2222_0004;
    tick();
    bus_rdata = 32'h3333_0005;
    tick();
    bus_rvalid = 0;
    tick();

    // FIFO full blocks requests; grant and response in one cycle keep the count.
    instr_req = 1; instr_addr = 32'h400; bus_gnt = 1;
    expect_rsp(1'b0, 32'h4444_0006, 1'b0);
    tick();
    instr_req = 0; data_req = 1; data_we = 1; data_addr = 32'h5000; data_wdata = 32'h55;
    expect_rsp(1'b1, 32'h5555_0007, 1'b0);
    tick();
    data_req = 0; instr_req = 1; instr_addr = 32'h404;
    @(negedge clk);
    chk("t5_full_bus_req", {31'd0, bus_req}, 32'd0);
    chk("t5_full_gnt", {31'd0, instr_gnt}, 32'd0);
    chk("t5_full_count", {29'd0, outstanding}, 32'd2);
    tick();
    instr_req = 0; bus_rvalid = 1; bus_rdata = 32'h4444_0006;
    tick();
    instr_req = 1; bus_rdata = 32'h5555_0007;
    expect_rsp(1'b0, 32'h6666_0008, 1'b0);
    @(negedge clk);
    chk("t5_gnt_pop", {30'd0, instr_gnt, data_rvalid}, 32'b11);
    chk("t5_count_before", {29'd0, outstanding}, 32'd1);
    tick();
    instr_req = 0; bus_rvalid = 0; data_req = 1; data_addr = 32'h5004;
    expect_rsp(1'b1, 32'h7777_0009, 1'b0);
    @(negedge clk);
    chk("t5_count_same", {29'd0, outstanding}, 32'd1);
    tick();
    data_req = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h6666_0008;
    @(negedge clk);
    chk("t5_count_two", {29'd0, outstanding}, 32'd2);
    tick();
    bus_rdata = 32'h7777_0009;
    tick();
    bus_rvalid = 0;
    @(negedge clk);
    chk("t5_count_end", {29'd0, outstanding}, 32'd0);
    tick();

    // Response with empty FIFO, then reset during WAIT_GNT.
    bus_rvalid = 1; bus_rdata = 32'hBAD;
    @(negedge clk);
    chk("t6_no_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
    tick();
    bus_rvalid = 0;
    @(negedge clk);
    chk("t6_proto_err", {31'd0, proto_err}, 32'd1);
    chk("t6_count0", {29'd0, outstanding}, 32'd0);
    tick();
    instr_req = 1; instr_addr = 32'h600; bus_gnt = 0;
    tick();
    @(negedge clk);
    chk("t6_wait_req", {31'd0, bus_req}, 32'd1);
    chk("t6_proto_sticky", {31'd0, proto_err}, 32'd1);
    #2;
    rst = 1;
    #1;
    chk("t6_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("t6_rst_proto", {31'd0, proto_err}, 32'd0);
    tick();
    instr_req = 0;
    tick();
    rst = 0;
    bus_rvalid = 1; bus_rdata = 32'hBAD2;
    tick();
    bus_rvalid = 0;
    @(negedge clk);
    chk("t6_post_rst_proto", {31'd0, proto_err}, 32'd1);
    rst = 1;
    tick();
    rst = 0;
    tick();

    // Round-robin instance: both requesting, grants alternate D,I,D,I.
    data_req = 1; data_we = 0; data_addr = 32'h7000; instr_req = 1; instr_addr = 32'h700;
    bus_gnt_r = 1;
    for (int i = 0; i < 4; i++) begin
      bus_rvalid_r = (i != 0);
      @(negedge clk);
      chk("rr_gnt", {30'd0, instr_gnt_r, data_gnt_r}, (i % 2 == 0) ? 32'b01 : 32'b10);
      chk("rr_outstanding_le2", {31'd0, outstanding_r <= 3'd2}, 32'd1);
      if (i != 0) chk("rr_rsp_route", {30'd0, instr_rvalid_r, data_rvalid_r}, (i % 2 == 1) ? 32'b01 : 32'b10);
      tick();
    end
    data_req = 0; instr_req = 0; bus_gnt_r = 0; bus_rvalid_r = 0;
    rst = 1;
    tick();
    rst = 0;
    tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
